// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states, the NOP
// encoding and the default reset vector.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] MIPS_NOP         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating counter of ack-less fetch cycles; expired marks the cycle that
// would be the TIMEOUT-th consecutive one without an acknowledge.
module fetch_timeout_ctr #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;
  logic [8:0] count_inc;

  assign count_inc = {1'b0, count} + 9'd1;
  assign expired   = enable && (count_inc >= {1'b0, TIMEOUT});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && (count != TIMEOUT)) begin
      count <= count_inc[7:0];
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC holder and instruction fetcher: one req/ack fetch per
// retire, with sticky error on misaligned targets or memory timeout.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [7:0]  TIMEOUT  = 8'd255,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      next_pc,
  input  logic             instr_ready,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retire_cnt
);

  fetch_state_t state, next_state;

  logic tmo_clear;
  logic tmo_enable;
  logic tmo_expired;
  logic load_instr;
  logic commit;
  logic misaligned;
  logic timed_out;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tmo_clear  = 1'b0;
    tmo_enable = 1'b0;
    load_instr = 1'b0;
    commit     = 1'b0;
    misaligned = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        tmo_clear  = 1'b1;
        next_state = FETCH;
      end
      FETCH: begin
        // An ack in the last permitted cycle still wins over the timeout.
        if (imem_ack) begin
          load_instr = 1'b1;
          next_state = EXEC;
        end else begin
          tmo_enable = 1'b1;
          if (tmo_expired) begin
            timed_out  = 1'b1;
            next_state = HALT;
          end
        end
      end
      EXEC: begin
        if (instr_ready && instr_valid) begin
          if (is_word_aligned(next_pc)) begin
            commit     = 1'b1;
            tmo_clear  = 1'b1;
            next_state = FETCH;
          end else begin
            misaligned = 1'b1;
            next_state = HALT;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // The request is registered off the next state so it is high for exactly
  // the cycles the FSM spends in FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= MIPS_NOP;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_err   <= 1'b0;
      retire_cnt  <= '0;
    end else begin
      imem_req <= (next_state == FETCH);
      if (load_instr) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (commit) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
        retire_cnt  <= retire_cnt + CNT_W'(1);
      end
      if (misaligned) begin
        instr_valid <= 1'b0;
        fetch_err   <= 1'b1;
      end
      if (timed_out) begin
        fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit: a memory responder and core
// stand-in drive the main instance; a short-timeout instance covers expiry.
module tb_pc_fetch_unit;

  localparam int          CNT_W      = 4;
  localparam logic [31:0] T_RESET_PC = 32'h0000_1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [31:0]      next_pc = 32'h0;
  logic             instr_ready = 1'b0;
  logic             imem_ack = 1'b0;
  logic [31:0]      imem_rdata = 32'h0;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             fetch_err;
  logic [CNT_W-1:0] retire_cnt;

  logic        t_rst_n = 1'b0;
  logic [31:0] t_next_pc = 32'h0;
  logic        t_instr_ready = 1'b0;
  logic        t_imem_ack = 1'b0;
  logic [31:0] t_imem_rdata = 32'h0;
  logic        t_imem_req;
  logic [31:0] t_imem_addr;
  logic [31:0] t_pc;
  logic [31:0] t_pc_plus4;
  logic [31:0] t_instr;
  logic        t_instr_valid;
  logic        t_fetch_err;
  logic [7:0]  t_retire_cnt;

  pc_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (8'd255),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (next_pc),
    .instr_ready (instr_ready),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .retire_cnt  (retire_cnt)
  );

  pc_fetch_unit #(
    .RESET_PC (T_RESET_PC),
    .TIMEOUT  (8'd4),
    .CNT_W    (8)
  ) dut_t (
    .clk         (clk),
    .rst_n       (t_rst_n),
    .next_pc     (t_next_pc),
    .instr_ready (t_instr_ready),
    .imem_ack    (t_imem_ack),
    .imem_rdata  (t_imem_rdata),
    .imem_req    (t_imem_req),
    .imem_addr   (t_imem_addr),
    .pc          (t_pc),
    .pc_plus4    (t_pc_plus4),
    .instr       (t_instr),
    .instr_valid (t_instr_valid),
    .fetch_err   (t_fetch_err),
    .retire_cnt  (t_retire_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic prev_valid = 1'b0;

  int tests    = 0;
  int failures = 0;

  // Architectural model: where the PC is, how many retires so far, halted.
  logic [31:0] model_pc     = 32'h0;
  logic [31:0] model_cnt    = 32'h0;
  logic        model_halted = 1'b0;
  logic [31:0] last_word    = 32'h0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising instr_valid must match the oldest pending fetch.
  always @(negedge clk) begin
    if (rst_n && instr_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected_valid: got instr %h, expected no pending fetch", instr);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("mon_instr", instr, mon_e.instr);
        checkOutput("mon_pc", pc, mon_e.pc);
        checkOutput("mon_cnt", 32'(retire_cnt), mon_e.cnt);
      end
    end
    prev_valid = instr_valid;
  end

  task automatic doReset();
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    imem_ack    = 1'b0;
    @(negedge clk);
    model_pc     = 32'h0;
    model_cnt    = 32'h0;
    model_halted = 1'b0;
    last_word    = 32'h0;
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_err", 32'(fetch_err), 32'd0);
    checkOutput("rst_cnt", 32'(retire_cnt), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic waitForReq();
    int n = 0;
    @(negedge clk);
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_wait", 32'(imem_req), 32'd1);
  endtask

  task automatic fetchWord(input int delay, input logic [31:0] word);
    waitForReq();
    for (int i = 0; i < delay; i++) begin
      checkOutput("fetch_addr", imem_addr, model_pc);
      checkOutput("fetch_valid_low", 32'(instr_valid), 32'd0);
      instr_ready = 1'($urandom_range(0, 1));
      next_pc     = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
      instr_ready = 1'b0;
      checkOutput("fetch_pc_hold", pc, model_pc);
    end
    checkOutput("fetch_addr", imem_addr, model_pc);
    imem_ack   = 1'b1;
    imem_rdata = word;
    sb_q.push_back('{instr: word, pc: model_pc, cnt: model_cnt & 32'hF});
    last_word = word;
    @(posedge clk);
    #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    @(negedge clk);
    checkOutput("valid_after_ack", 32'(instr_valid), 32'd1);
  endtask

  task automatic retireTo(input logic [31:0] npc, input int idle);
    for (int i = 0; i < idle; i++) begin
      checkOutput("exec_instr_hold", instr, last_word);
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
      imem_ack = 1'b0;
    end
    checkOutput("exec_instr_hold", instr, last_word);
    checkOutput("exec_valid", 32'(instr_valid), 32'd1);
    next_pc     = npc;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    if (npc[1:0] == 2'b00) begin
      model_pc  = npc;
      model_cnt = model_cnt + 32'd1;
    end else begin
      model_halted = 1'b1;
    end
    @(negedge clk);
    checkOutput("retire_pc", pc, model_pc);
    checkOutput("retire_cnt", 32'(retire_cnt), model_cnt & 32'hF);
    checkOutput("retire_valid", 32'(instr_valid), 32'd0);
    checkOutput("retire_err", 32'(fetch_err), 32'(model_halted));
    checkOutput("retire_req", 32'(imem_req), 32'(!model_halted));
    checkOutput("retire_addr", imem_addr, model_pc);
    checkOutput("pc_plus4", pc_plus4, model_pc + 32'd4);
  endtask

  task automatic applyStimulus(input int delay, input logic [31:0] word, input logic [31:0] npc, input int idle);
    fetchWord(delay, word);
    retireTo(npc, idle);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] npc;
    logic [31:0] word;

    doReset();
    applyStimulus(0, 32'h2008_0005, 32'h0000_0040, 0);
    applyStimulus(5, $urandom, 32'h0000_0100, 2);

    for (int n = 0; n < 30; n++) begin
      word = $urandom;
      if ($urandom_range(0, 9) == 0) npc = model_pc;
      else npc = $urandom & 32'hFFFF_FFFC;
      applyStimulus($urandom_range(0, 6), word, npc, $urandom_range(0, 3));
    end

    applyStimulus(1, $urandom, 32'hFFFF_FFFC, 0);
    checkOutput("pc_plus4_wrap", pc_plus4, 32'h0000_0000);
    applyStimulus(0, $urandom, 32'h0000_0200, 1);

    // Misaligned target halts; the unit then ignores acks and readies.
    fetchWord(2, $urandom);
    retireTo(32'h0000_0042, 1);
    for (int i = 0; i < 4; i++) begin
      imem_ack    = 1'b1;
      imem_rdata  = $urandom;
      instr_ready = 1'b1;
      next_pc     = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
      checkOutput("halt_pc", pc, model_pc);
      checkOutput("halt_req", 32'(imem_req), 32'd0);
      checkOutput("halt_err", 32'(fetch_err), 32'd1);
      checkOutput("halt_valid", 32'(instr_valid), 32'd0);
      checkOutput("halt_instr", instr, last_word);
      checkOutput("halt_cnt", 32'(retire_cnt), model_cnt & 32'hF);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b0;

    // Reset in the middle of a fetch, with the stale ack arriving just after.
    doReset();
    waitForReq();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    checkOutput("midrst_valid", 32'(instr_valid), 32'd0);
    checkOutput("midrst_instr", instr, 32'h0);
    checkOutput("midrst_pc", pc, 32'h0);
    checkOutput("midrst_req", 32'(imem_req), 32'd1);
    checkOutput("midrst_addr", imem_addr, 32'h0);
    applyStimulus(2, $urandom, 32'h0000_0010, 1);

    // Short-timeout instance: one good fetch, then a fetch that never acks.
    @(negedge clk);
    checkOutput("t_rst_pc", t_pc, T_RESET_PC);
    checkOutput("t_rst_err", 32'(t_fetch_err), 32'd0);
    t_rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t_req", 32'(t_imem_req), 32'd1);
    checkOutput("t_addr", t_imem_addr, T_RESET_PC);
    word         = $urandom;
    t_imem_ack   = 1'b1;
    t_imem_rdata = word;
    @(negedge clk);
    t_imem_ack = 1'b0;
    checkOutput("t_valid", 32'(t_instr_valid), 32'd1);
    checkOutput("t_instr", t_instr, word);
    t_next_pc     = 32'h0000_0080;
    t_instr_ready = 1'b1;
    @(negedge clk);
    t_instr_ready = 1'b0;
    checkOutput("t_commit_pc", t_pc, 32'h0000_0080);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t_no_err_early", 32'(t_fetch_err), 32'd0);
      checkOutput("t_req_waiting", 32'(t_imem_req), 32'd1);
      @(negedge clk);
    end
    checkOutput("t_timeout_err", 32'(t_fetch_err), 32'd1);
    checkOutput("t_timeout_req", 32'(t_imem_req), 32'd0);
    checkOutput("t_timeout_pc", t_pc, 32'h0000_0080);
    repeat (3) @(negedge clk);
    checkOutput("t_err_sticky", 32'(t_fetch_err), 32'd1);
    t_rst_n = 1'b0;
    @(negedge clk);
    t_rst_n = 1'b1;
    checkOutput("t_rst2_pc", t_pc, T_RESET_PC);
    checkOutput("t_rst2_err", 32'(t_fetch_err), 32'd0);
    checkOutput("t_rst2_req", 32'(t_imem_req), 32'd0);

    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
